pattern_gen: RTL

Serial pattern transmitter: captures a WIDTH-bit pattern and a repeat count on a start strobe, then shifts the pattern out MSB-first, one bit per clock. Repetitions are separated by a programmable idle gap. It is the source end of the serial bit stream that the team's sequence detectors consume, and drives the `in` port of a detector FSM in self-checking benches and in the FSM demo top.

---
 rtl/pattern_pkg.sv | 22 ++
 rtl/pattern_shreg.sv | 38 +++
 rtl/pattern_gen.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/pattern_pkg.sv
// Shared FSM encodings and a constant clog2 helper for the serial pattern source and its detector-side peers.
// Pure declarations: no logic, no latency, no flow control.
package pattern_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SEND = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_SEND = ST_SEND,
      S_GAP  = ST_GAP
   } state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/pattern_shreg.sv
// WIDTH-bit parallel-load, left-shift register; the MSB is the serial output.
// Load/shift take effect on the next edge (1 cycle); load has priority and there is no stall path.
module pattern_shreg
   import pattern_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] din,
   output logic             msb
);

   logic [WIDTH-1:0] sr_q;
   logic [WIDTH-1:0] sr_d;

   always_comb begin
      sr_d = sr_q;
      if (load) begin
         sr_d = din;
      end else if (shift) begin
         sr_d = {sr_q[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign msb = sr_q[WIDTH-1];

endmodule

// File: rtl/pattern_gen.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, repeated with idle gaps, then pulses done.
// First bit is valid one edge after start is accepted; start while busy is dropped, never queued.
module pattern_gen
   import pattern_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNTW  = 4,
   parameter int GAP   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] pattern,
   input  logic [CNTW-1:0]  repeat_n,
   output logic             out,
   output logic             out_valid,
   output logic             busy,
   output logic             done
);

   localparam int BW = clog2(WIDTH);
   localparam int GW = (clog2(GAP + 1) > 0) ? clog2(GAP + 1) : 1;
   localparam logic [BW-1:0]   BIT_LAST = BW'(WIDTH - 1);
   localparam logic [GW-1:0]   GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
   localparam logic [CNTW-1:0] REP_ONE  = CNTW'(1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] cap_q, cap_d;
   logic [CNTW-1:0]  rep_q, rep_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic [GW-1:0]    gap_q, gap_d;
   logic             out_valid_q, out_valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             sr_load;
   logic             sr_shift;
   logic [WIDTH-1:0] sr_din;
   logic             sr_msb;

   always_comb begin
      state_d     = state_q;
      cap_d       = cap_q;
      rep_d       = rep_q;
      bit_d       = bit_q;
      gap_d       = gap_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      sr_load     = 1'b0;
      sr_shift    = 1'b0;
      sr_din      = '0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               cap_d       = pattern;
               rep_d       = (repeat_n == '0) ? REP_ONE : repeat_n;
               sr_load     = 1'b1;
               sr_din      = pattern;
               bit_d       = BIT_LAST;
               out_valid_d = 1'b1;
               busy_d      = 1'b1;
               state_d     = S_SEND;
            end
         end
         S_SEND: begin
            if (bit_q != '0) begin
               sr_shift = 1'b1;
               bit_d    = bit_q - 1'b1;
            end else if (rep_q > REP_ONE) begin
               // Counter stops at 1 so the final repetition is recognised without wrapping.
               rep_d = rep_q - 1'b1;
               if (GAP > 0) begin
                  sr_load     = 1'b1;
                  out_valid_d = 1'b0;
                  gap_d       = GAP_LAST;
                  state_d     = S_GAP;
               end else begin
                  sr_load = 1'b1;
                  sr_din  = cap_q;
                  bit_d   = BIT_LAST;
               end
            end else begin
               // Loading zeros forces the serial line low while idle.
               sr_load     = 1'b1;
               out_valid_d = 1'b0;
               busy_d      = 1'b0;
               done_d      = 1'b1;
               state_d     = S_IDLE;
            end
         end
         S_GAP: begin
            if (gap_q == '0) begin
               sr_load     = 1'b1;
               sr_din      = cap_q;
               bit_d       = BIT_LAST;
               out_valid_d = 1'b1;
               state_d     = S_SEND;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cap_q       <= '0;
         rep_q       <= '0;
         bit_q       <= '0;
         gap_q       <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cap_q       <= cap_d;
         rep_q       <= rep_d;
         bit_q       <= bit_d;
         gap_q       <= gap_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   pattern_shreg #(
      .WIDTH(WIDTH)
   ) u_shreg (
      .clk  (clk),
      .reset(reset),
      .load (sr_load),
      .shift(sr_shift),
      .din  (sr_din),
      .msb  (sr_msb)
   );

   assign out       = sr_msb;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
